// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int MAX_WR    = 8;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  // Highest-index matching write port, or -1 when no port matches.
  function automatic int bypass_sel(input logic [MAX_WR-1:0] hit);
    int sel;
    sel = -1;
    for (int p = 0; p < MAX_WR; p++) begin
      if (hit[p]) sel = p;
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bundle of write, read and issue/flush signals between the core and the register file.
interface reg_file_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                flush;
  logic                any_busy;

  modport master (
    output we, wa, wd, ra, iss_valid, iss_rd, flush,
    input  rd, rd_busy, any_busy
  );

  modport slave (
    input  we, wa, wd, ra, iss_valid, iss_rd, flush,
    output rd, rd_busy, any_busy
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits: set on issue, cleared on writeback, wiped by flush.
module rf_scoreboard #(
  parameter int NREGS = 32,
  parameter int NWR   = 2,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              flush,
  output logic [NREGS-1:0]  pend_o,
  output logic              any_busy
);

  logic [NREGS-1:0] pend_d, pend_q;

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    pend_d = pend_q;
    for (int p = 0; p < NWR; p++) begin
      if (we[p]) pend_d[wa[p*AW +: AW]] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) pend_d[iss_rd] = 1'b1;
    if (flush) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_d;
  end

  assign pend_o   = pend_q;
  assign any_busy = |pend_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with optional same-cycle write bypass and pending-write tracking.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]     regs_d [NREGS];
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NREGS-1:0]    pend;
  logic [NRD*XLEN-1:0] rd_c;
  logic [NRD-1:0]      busy_c;
  logic [AW-1:0]       raddr;
  logic [MAX_WR-1:0]   hit;
  int                  sel;

  // Ascending port order makes the highest-index writer win on collisions.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NWR; p++) begin
      if (bus.we[p] && (bus.wa[p*AW +: AW] != '0))
        regs_d[bus.wa[p*AW +: AW]] = bus.wd[p*XLEN +: XLEN];
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '{default: '0};
    else      regs_q <= regs_d;
  end

  rf_scoreboard #(.NREGS(NREGS), .NWR(NWR), .AW(AW)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .we        (bus.we),
    .wa        (bus.wa),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .flush     (bus.flush),
    .pend_o    (pend),
    .any_busy  (bus.any_busy)
  );

  always_comb begin
    rd_c   = '0;
    busy_c = '0;
    raddr  = '0;
    hit    = '0;
    sel    = -1;
    for (int r = 0; r < NRD; r++) begin
      raddr = bus.ra[r*AW +: AW];
      hit   = '0;
      for (int p = 0; p < NWR; p++)
        hit[p] = bus.we[p] && (bus.wa[p*AW +: AW] == raddr) && (raddr != '0);
      sel = bypass_sel(hit);
      if (rst && (raddr != '0)) begin
        if ((BYPASS != 0) && (sel >= 0)) begin
          rd_c[r*XLEN +: XLEN] = bus.wd[sel*XLEN +: XLEN];
          busy_c[r]            = 1'b0;
        end else begin
          rd_c[r*XLEN +: XLEN] = regs_q[raddr];
          busy_c[r]            = pend[raddr];
        end
      end
    end
  end

  assign bus.rd      = rd_c;
  assign bus.rd_busy = busy_c;

endmodule

// File: tb/tb_reg_file_mp.sv
// Drives a bypassing and a non-bypassing register file with identical stimulus and scores both.
module tb_reg_file_mp;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) if1 ();
  reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) if0 ();

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));
  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));

  typedef struct packed {
    logic [1:0][31:0] r1;
    logic [1:0]       b1;
    logic [1:0][31:0] r0;
    logic [1:0]       b0;
    logic             any;
  } exp_t;

  exp_t   q[$];
  xword_t mem [32];
  logic [31:0] pend;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle's response is compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("byp_rd0",   if1.rd[31:0],        e.r1[0]);
      chk("byp_rd1",   if1.rd[63:32],       e.r1[1]);
      chk("byp_busy",  {30'd0, if1.rd_busy}, {30'd0, e.b1});
      chk("nob_rd0",   if0.rd[31:0],        e.r0[0]);
      chk("nob_rd1",   if0.rd[63:32],       e.r0[1]);
      chk("nob_busy",  {30'd0, if0.rd_busy}, {30'd0, e.b0});
      chk("any_busy",  {31'd0, if1.any_busy}, {31'd0, e.any});
      chk("any_busy0", {31'd0, if0.any_busy}, {31'd0, e.any});
    end
  end

  task automatic cyc(input logic [1:0] we, input reg_addr_t wa0, input xword_t wd0,
                     input reg_addr_t wa1, input xword_t wd1,
                     input reg_addr_t ra0, input reg_addr_t ra1,
                     input logic iv, input reg_addr_t ir, input logic fl, input logic rn);
    reg_addr_t wa[2];
    xword_t    wd[2];
    reg_addr_t ra[2];
    exp_t      e;
    @(posedge clk);
    #1;
    wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
    if1.we = we; if1.wa = {wa1, wa0}; if1.wd = {wd1, wd0}; if1.ra = {ra1, ra0};
    if1.iss_valid = iv; if1.iss_rd = ir; if1.flush = fl;
    if0.we = we; if0.wa = {wa1, wa0}; if0.wd = {wd1, wd0}; if0.ra = {ra1, ra0};
    if0.iss_valid = iv; if0.iss_rd = ir; if0.flush = fl;
    rst = rn;
    e = '0;
    if (rn) begin
      for (int r = 0; r < 2; r++) begin
        logic   h;
        xword_t bd;
        h = 1'b0; bd = '0;
        for (int p = 0; p < 2; p++)
          if (we[p] && wa[p] == ra[r] && ra[r] != 0) begin h = 1'b1; bd = wd[p]; end
        e.r0[r] = (ra[r] == 0) ? 32'd0 : mem[ra[r]];
        e.b0[r] = pend[ra[r]];
        e.r1[r] = (ra[r] == 0) ? 32'd0 : (h ? bd : mem[ra[r]]);
        e.b1[r] = pend[ra[r]] && !h;
      end
      e.any = |pend;
    end
    q.push_back(e);
    // Advance the reference state to what the coming edge should commit.
    if (!rn) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      pend = '0;
    end else begin
      for (int p = 0; p < 2; p++) if (we[p] && wa[p] != 0) mem[wa[p]] = wd[p];
      if (fl) pend = '0;
      else begin
        for (int p = 0; p < 2; p++) if (we[p]) pend[wa[p]] = 1'b0;
        if (iv && ir != 0) pend[ir] = 1'b1;
      end
    end
  endtask

  task automatic rd2(input reg_addr_t a0, input reg_addr_t a1);
    cyc(2'b00, 0, 0, 0, 0, a0, a1, 1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    pend = '0;
    if1.we = '0; if1.wa = '0; if1.wd = '0; if1.ra = '0; if1.iss_valid = 0; if1.iss_rd = '0; if1.flush = 0;
    if0.we = '0; if0.wa = '0; if0.wd = '0; if0.ra = '0; if0.iss_valid = 0; if0.iss_rd = '0; if0.flush = 0;
    cyc(2'b11, 5, 32'h1, 6, 32'h2, 5, 6, 1'b1, 7, 1'b0, 1'b0);
    cyc(2'b00, 0, 0, 0, 0, 5, 0, 1'b0, 0, 1'b0, 1'b0);
    // Dual write then read-back; writes to x0 are dropped.
    cyc(2'b11, 3, 32'h11, 4, 32'h22, 3, 4, 1'b0, 0, 1'b0, 1'b1);
    rd2(3, 4);
    cyc(2'b11, 0, 32'hFFFF, 0, 32'hFFFF, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    rd2(0, 3);
    // Collision on x7: port 1 wins.
    cyc(2'b11, 7, 32'hAAAA, 7, 32'h5555, 7, 7, 1'b0, 0, 1'b0, 1'b1);
    rd2(7, 4);
    // Same-cycle bypass of x9.
    cyc(2'b01, 9, 32'h1234, 0, 0, 9, 9, 1'b0, 0, 1'b0, 1'b1);
    rd2(9, 7);
    // Scoreboard set, clear, and set-beats-clear.
    cyc(2'b00, 0, 0, 0, 0, 6, 0, 1'b1, 6, 1'b0, 1'b1);
    rd2(6, 6);
    cyc(2'b10, 0, 0, 6, 32'h66, 6, 5, 1'b0, 0, 1'b0, 1'b1);
    rd2(6, 5);
    cyc(2'b01, 6, 32'h67, 0, 0, 5, 4, 1'b1, 6, 1'b0, 1'b1);
    rd2(6, 0);
    // Flush beats a concurrent issue; iss_rd=0 never sets busy.
    cyc(2'b00, 0, 0, 0, 0, 2, 8, 1'b1, 2, 1'b0, 1'b1);
    cyc(2'b00, 0, 0, 0, 0, 2, 8, 1'b1, 8, 1'b0, 1'b1);
    cyc(2'b00, 0, 0, 0, 0, 8, 10, 1'b1, 10, 1'b0, 1'b1);
    cyc(2'b00, 0, 0, 0, 0, 10, 11, 1'b1, 11, 1'b1, 1'b1);
    rd2(2, 11);
    cyc(2'b00, 0, 0, 0, 0, 0, 2, 1'b1, 0, 1'b0, 1'b1);
    rd2(0, 8);
    // Mid-run reset clears state at once and loses the in-flight write.
    cyc(2'b01, 5, 32'hDEADBEEF, 0, 0, 3, 4, 1'b1, 12, 1'b0, 1'b1);
    rd2(5, 12);
    cyc(2'b01, 5, 32'h77, 0, 0, 5, 12, 1'b1, 13, 1'b0, 1'b0);
    cyc(2'b00, 0, 0, 0, 0, 5, 12, 1'b0, 0, 1'b0, 1'b0);
    rd2(5, 3);
    // Random traffic on a narrow address range to force collisions and hazards.
    for (int i = 0; i < 400; i++) begin
      cyc(2'($urandom), reg_addr_t'($urandom_range(0, 15)), $urandom,
          reg_addr_t'($urandom_range(0, 15)), $urandom,
          reg_addr_t'($urandom_range(0, 15)), reg_addr_t'($urandom_range(0, 15)),
          1'($urandom), reg_addr_t'($urandom_range(0, 15)),
          ($urandom_range(0, 15) == 0), 1'b1);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
